// File: rtl/tx_serial_framer.sv
// Serial word framer: low start bit, LSB-first data, idle-high gap between frames.
// Define TX_SERIAL_FRAMER_PARITY_EN to append an even-parity bit to every word.
module tx_serial_framer #(
    parameter int WORD_WIDTH = 8,
    parameter int GAP_BITS   = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [WORD_WIDTH-1:0] word_in,
    input  logic                  word_available,
    input  logic                  frame_complete,
    output logic                  word_read,
    output logic                  data_out,
    output logic                  busy,
    output logic                  underrun,
    output logic                  frame_done
);

    localparam int CW = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(WORD_WIDTH - 1);
    localparam logic [4:0] GAP_LOAD = 5'((GAP_BITS > 1) ? GAP_BITS - 2 : 0);
`ifdef TX_SERIAL_FRAMER_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        PARITY,
        DECIDE,
        GAP
    } state_t;

    state_t                  state_q, state_d;
    logic [WORD_WIDTH-1:0]   shreg_q, shreg_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [4:0]              gcnt_q, gcnt_d;
    logic                    last_q, last_d;
    logic                    par_q, par_d;
    logic                    data_d, read_d, busy_d, und_d, done_d;
    logic                    load;
    state_t                  gap_next;

    // With a single gap bit the high slot after DECIDE is already the last one.
    assign gap_next = (GAP_BITS > 1) ? GAP : IDLE;

    // Outputs are computed one cycle ahead and registered with the state.
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        gcnt_d  = gcnt_q;
        last_d  = last_q;
        par_d   = par_q;
        data_d  = 1'b1;
        read_d  = 1'b0;
        busy_d  = 1'b1;
        und_d   = 1'b0;
        done_d  = 1'b0;
        load    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (word_available) load = 1'b1;
                else busy_d = 1'b0;
            end
            SHIFT: begin
                data_d  = shreg_q[0];
                shreg_d = shreg_q >> 1;
                if (cnt_q == '0) begin
                    if (PAR_EN) state_d = PARITY;
                    else state_d = DECIDE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            PARITY: begin
                data_d  = par_q;
                state_d = DECIDE;
            end
            DECIDE: begin
                if (last_q) begin
                    done_d  = 1'b1;
                    state_d = gap_next;
                    gcnt_d  = GAP_LOAD;
                end else if (word_available) begin
                    load = 1'b1;
                end else begin
                    und_d   = 1'b1;
                    state_d = gap_next;
                    gcnt_d  = GAP_LOAD;
                end
            end
            GAP: begin
                if (gcnt_q == '0) state_d = IDLE;
                else gcnt_d = gcnt_q - 1'b1;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase

        if (load) begin
            shreg_d = word_in;
            last_d  = frame_complete;
            par_d   = ^word_in;
            cnt_d   = CNT_LOAD;
            data_d  = 1'b0;
            read_d  = 1'b1;
            state_d = SHIFT;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            shreg_q    <= '0;
            cnt_q      <= '0;
            gcnt_q     <= '0;
            last_q     <= 1'b0;
            par_q      <= 1'b0;
            data_out   <= 1'b1;
            word_read  <= 1'b0;
            busy       <= 1'b0;
            underrun   <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            cnt_q      <= cnt_d;
            gcnt_q     <= gcnt_d;
            last_q     <= last_d;
            par_q      <= par_d;
            data_out   <= data_d;
            word_read  <= read_d;
            busy       <= busy_d;
            underrun   <= und_d;
            frame_done <= done_d;
        end
    end

endmodule

// File: tb/tb_tx_serial_framer.sv
// Bench for tx_serial_framer: two instances (8b/gap 2 and 12b/gap 4),
// per-cycle expected line vectors queued by stimulus and popped by monitors.
module tb_tx_serial_framer;

`ifdef TX_SERIAL_FRAMER_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int K_MORE = 0;
    localparam int K_DONE = 1;
    localparam int K_UND  = 2;
    // vector order: {data_out, word_read, busy, underrun, frame_done}
    localparam logic [4:0] IDLE_V = 5'b10000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rst_seen = 1'b0;

    logic [7:0]  win_a = '0;
    logic        avail_a = 1'b0, fc_a = 1'b0;
    logic        rd_a, dout_a, busy_a, und_a, done_a;
    logic [11:0] win_b = '0;
    logic        avail_b = 1'b0, fc_b = 1'b0;
    logic        rd_b, dout_b, busy_b, und_b, done_b;

    logic [4:0]  qa[$];
    logic [4:0]  qb[$];
    logic [64:0] fa[$];
    logic [64:0] fb[$];
    bit          run_a = 1'b0, run_b = 1'b0;
    int          compared = 0;
    int          failed = 0;

    always #5 clk = ~clk;

    tx_serial_framer #(.WORD_WIDTH(8), .GAP_BITS(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .word_in(win_a),
        .word_available(avail_a), .frame_complete(fc_a),
        .word_read(rd_a), .data_out(dout_a), .busy(busy_a),
        .underrun(und_a), .frame_done(done_a)
    );

    tx_serial_framer #(.WORD_WIDTH(12), .GAP_BITS(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .word_in(win_b),
        .word_available(avail_b), .frame_complete(fc_b),
        .word_read(rd_b), .data_out(dout_b), .busy(busy_b),
        .underrun(und_b), .frame_done(done_b)
    );

    always @(posedge clk) rst_seen <= rst_n;

    task automatic chk(input string nm, input logic [4:0] a, input logic [4:0] e);
        compared++;
        if (a !== e) begin
            failed++;
            $display("FAIL %s: got %b want %b (dout,rd,busy,und,done) t=%0t",
                     nm, a, e, $time);
        end
    endtask

    // Upstream show-ahead FIFO models: pop on word_read.
    always @(negedge clk) begin
        if (rd_a && fa.size() != 0) fa.delete(0);
        if (rd_b && fb.size() != 0) fb.delete(0);
        avail_a = (fa.size() != 0);
        fc_a    = avail_a ? fa[0][64] : 1'b0;
        win_a   = avail_a ? fa[0][7:0] : '0;
        avail_b = (fb.size() != 0);
        fc_b    = avail_b ? fb[0][64] : 1'b0;
        win_b   = avail_b ? fb[0][11:0] : '0;
    end

    always @(negedge clk) begin : mon_a
        logic [4:0] act, e;
        act = {dout_a, rd_a, busy_a, und_a, done_a};
        if (!rst_seen) begin
            qa.delete();
            run_a = 1'b0;
            chk("reset_a", act, IDLE_V);
        end else if (run_a || (rd_a && qa.size() != 0)) begin
            run_a = 1'b1;
            e = qa.pop_front();
            chk("line_a", act, e);
            if (qa.size() == 0) run_a = 1'b0;
        end else begin
            chk("idle_a", act, IDLE_V);
        end
    end

    always @(negedge clk) begin : mon_b
        logic [4:0] act, e;
        act = {dout_b, rd_b, busy_b, und_b, done_b};
        if (!rst_seen) begin
            qb.delete();
            run_b = 1'b0;
            chk("reset_b", act, IDLE_V);
        end else if (run_b || (rd_b && qb.size() != 0)) begin
            run_b = 1'b1;
            e = qb.pop_front();
            chk("line_b", act, e);
            if (qb.size() == 0) run_b = 1'b0;
        end else begin
            chk("idle_b", act, IDLE_V);
        end
    end

    task automatic put(input bit b, input logic [4:0] v);
        if (b) qb.push_back(v);
        else qa.push_back(v);
    endtask

    task automatic exp_word(input bit b, input logic [63:0] w, input int kind,
                            input bit p, input bit last);
        int ww;
        int gap;
        ww  = b ? 12 : 8;
        gap = b ? 4 : 2;
        put(b, 5'b01100);
        for (int i = 0; i < ww; i++) put(b, {w[i], 4'b0100});
        if (PAR != 0) put(b, {p, 4'b0100});
        if (kind == K_DONE) begin
            put(b, 5'b10101);
            for (int i = 1; i < gap; i++) put(b, 5'b10100);
        end else if (kind == K_UND) begin
            put(b, 5'b10110);
            for (int i = 1; i < gap; i++) put(b, 5'b10100);
        end
        if (last) put(b, IDLE_V);
    endtask

    task automatic send(input bit b, input logic [63:0] w, input bit fc,
                        input int kind, input bit p, input bit last);
        exp_word(b, w, kind, p, last);
        if (b) fb.push_back({fc, w});
        else fa.push_back({fc, w});
    endtask

    task automatic drain(input string nm);
        int n;
        n = 0;
        while ((qa.size() != 0 || qb.size() != 0) && n < 400) begin
            @(negedge clk);
            n++;
        end
        compared++;
        if (n >= 400) begin
            failed++;
            $display("FAIL %s: timeout, %0d/%0d vectors left, want 0",
                     nm, qa.size(), qb.size());
            qa.delete();
            qb.delete();
            fa.delete();
            fb.delete();
            run_a = 1'b0;
            run_b = 1'b0;
        end
        repeat (3) @(negedge clk);
        #1;
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(negedge clk);
        #1;

        // single word 0xA5 (parity 0)
        send(0, 64'hA5, 1'b1, K_DONE, 1'b0, 1'b1);
        drain("single_a5");

        // two-word frame 0x01, 0x80 (parity 1, 1)
        send(0, 64'h01, 1'b0, K_MORE, 1'b1, 1'b0);
        send(0, 64'h80, 1'b1, K_DONE, 1'b1, 1'b1);
        drain("two_word");

        // underrun on 0x3C (parity 0)
        send(0, 64'h3C, 1'b0, K_UND, 1'b0, 1'b1);
        drain("underrun");

        // separate frames 0xA5 (parity 0) and 0x07 (parity 1)
        send(0, 64'hA5, 1'b1, K_DONE, 1'b0, 1'b1);
        drain("par_a5");
        send(0, 64'h07, 1'b1, K_DONE, 1'b1, 1'b1);
        drain("par_07");

        // back-to-back single-word frames, gap 2
        send(0, 64'hF0, 1'b1, K_DONE, 1'b0, 1'b0);
        send(0, 64'h0F, 1'b1, K_DONE, 1'b0, 1'b1);
        drain("b2b_gap2");

        // 12-bit words, gap 4, continuous availability
        send(1, 64'hABC, 1'b1, K_DONE, 1'b1, 1'b0);
        send(1, 64'h123, 1'b1, K_DONE, 1'b0, 1'b0);
        send(1, 64'h800, 1'b1, K_DONE, 1'b1, 1'b1);
        drain("b2b_gap4");

        // reset during the 4th data bit of 0x5A
        send(0, 64'h5A, 1'b1, K_DONE, 1'b0, 1'b1);
        n = 0;
        @(negedge clk);
        while (!rd_a && n < 50) begin
            @(negedge clk);
            n++;
        end
        compared++;
        if (!rd_a) begin
            failed++;
            $display("FAIL reset_start: word_read got %b want 1", rd_a);
        end
        repeat (4) @(negedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        #1 rst_n = 1'b1;
        drain("reset_flush");

        // clean restart after reset
        send(0, 64'hC3, 1'b1, K_DONE, 1'b0, 1'b1);
        drain("after_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
